// File: rtl/ex_stage.sv
// ex_stage: MIPS EX stage (ALU, branch target, EX/MEM register); iterative multiplier when EX_MUL_EN is defined
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  wb_in,
  input  logic [2:0]  m_in,
  input  logic [1:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic [31:0] pc_in,
  input  logic [31:0] read_data1_in,
  input  logic [31:0] read_data2_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  output logic [1:0]  wb_out,
  output logic [2:0]  m_out,
  output logic [31:0] branch_target,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [4:0]  dest_reg,
  output logic        stall_out
);
  logic [31:0] op_b, alu_res, bt;
  logic [4:0]  dest_sel;
  logic        start, busy, done;
  logic [31:0] mul_res, mul_bt, mul_wd;
  logic [1:0]  mul_wb;
  logic [2:0]  mul_m;
  logic [4:0]  mul_dest;
  always_comb begin
    op_b     = alu_src ? imm_in : read_data2_in;
    dest_sel = reg_dst ? rd_in : rt_in;
    bt       = pc_in + (imm_in << 2);
    alu_res  = '0;
    case (alu_op)
      2'b00: alu_res = read_data1_in + op_b;
      2'b01: alu_res = read_data1_in - op_b;
      2'b10:
        case (imm_in[5:0])
          6'h20:   alu_res = read_data1_in + op_b;
          6'h22:   alu_res = read_data1_in - op_b;
          6'h24:   alu_res = read_data1_in & op_b;
          6'h25:   alu_res = read_data1_in | op_b;
          6'h2a:   alu_res = {31'b0, $signed(read_data1_in) < $signed(op_b)};
          default: alu_res = '0;
        endcase
      default: alu_res = '0;
    endcase
  end
`ifdef EX_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] mul_a, mul_b, acc;
  logic        is_mul;
  always_comb begin
    is_mul   = alu_op == 2'b10 && imm_in[5:0] == 6'h18;
    busy     = state == BUSY;
    start    = !busy && is_mul;
    done     = busy && cnt == 5'd31;
    state_nx = start ? BUSY : (done ? IDLE : state);
    mul_res  = acc + (mul_b[0] ? mul_a : 32'd0);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        mul_a    <= read_data1_in;
        mul_b    <= op_b;
        acc      <= '0;
        cnt      <= '0;
        mul_wb   <= wb_in;
        mul_m    <= m_in;
        mul_dest <= dest_sel;
        mul_bt   <= bt;
        mul_wd   <= read_data2_in;
      end else if (busy) begin
        acc   <= mul_res;
        mul_a <= mul_a << 1;
        mul_b <= mul_b >> 1;
        cnt   <= cnt + 5'd1;
      end
    end
  end
  assign stall_out = busy;
`else
  assign start     = 1'b0;
  assign busy      = 1'b0;
  assign done      = 1'b0;
  assign mul_res   = '0;
  assign mul_bt    = '0;
  assign mul_wd    = '0;
  assign mul_wb    = '0;
  assign mul_m     = '0;
  assign mul_dest  = '0;
  assign stall_out = 1'b0;
`endif
  // Capture edge and non-final multiply iterations emit a bubble downstream
  always_ff @(posedge clock) begin
    if (reset || start || (busy && !done)) begin
      wb_out        <= '0;
      m_out         <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      write_data    <= '0;
      dest_reg      <= '0;
    end else if (done) begin
      wb_out        <= mul_wb;
      m_out         <= mul_m;
      branch_target <= mul_bt;
      zero          <= mul_res == '0;
      alu_result    <= mul_res;
      write_data    <= mul_wd;
      dest_reg      <= mul_dest;
    end else begin
      wb_out        <= wb_in;
      m_out         <= m_in;
      branch_target <= bt;
      zero          <= alu_res == '0;
      alu_result    <= alu_res;
      write_data    <= read_data2_in;
      dest_reg      <= dest_sel;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
  logic        clock, reset;
  logic [1:0]  wb_in, alu_op;
  logic [2:0]  m_in;
  logic        alu_src, reg_dst;
  logic [31:0] pc_in, read_data1_in, read_data2_in, imm_in;
  logic [4:0]  rt_in, rd_in;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [31:0] branch_target, alu_result, write_data;
  logic        zero, stall_out;
  logic [4:0]  dest_reg;
  int n_chk = 0;
  int n_pass = 0;

  ex_stage dut (
    .clock(clock), .reset(reset), .wb_in(wb_in), .m_in(m_in), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .pc_in(pc_in), .read_data1_in(read_data1_in),
    .read_data2_in(read_data2_in), .imm_in(imm_in), .rt_in(rt_in), .rd_in(rd_in),
    .wb_out(wb_out), .m_out(m_out), .branch_target(branch_target), .zero(zero),
    .alu_result(alu_result), .write_data(write_data), .dest_reg(dest_reg), .stall_out(stall_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return 32'd0;
    if (f == 6'h20) return a + b;
    if (f == 6'h22) return a - b;
    if (f == 6'h24) return a & b;
    if (f == 6'h25) return a | b;
    if (f == 6'h2a) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic set_in(input logic [1:0] op, input logic src, input logic dst,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [1:0] wb, input logic [2:0] m);
    alu_op = op; alu_src = src; reg_dst = dst; pc_in = pc; read_data1_in = a;
    read_data2_in = b; imm_in = imm; rt_in = rt; rd_in = rd; wb_in = wb; m_in = m;
  endtask

  task automatic junk_in();
    set_in(2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
           $urandom, 5'($urandom), 5'($urandom), 2'($urandom), 3'($urandom));
  endtask

  task automatic exec_check(input string tag);
    logic [31:0] ob, res, bt, wd;
    logic [4:0]  dst;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        is_mul;
    ob     = alu_src ? imm_in : read_data2_in;
    bt     = pc_in + (imm_in << 2);
    wd     = read_data2_in;
    dst    = reg_dst ? rd_in : rt_in;
    wb     = wb_in;
    m      = m_in;
    is_mul = alu_op == 2'd2 && imm_in[5:0] == 6'h18;
    res    = model_alu(alu_op, imm_in[5:0], read_data1_in, ob);
`ifdef EX_MUL_EN
    if (is_mul) begin
      res = read_data1_in * ob;
      tick();
      for (int i = 0; i < 32; i++) begin
        chk({tag, "_stall"}, 32'(stall_out), 32'd1);
        chk({tag, "_bubble"}, {25'd0, wb_out, m_out} | alu_result | 32'(dest_reg), 32'd0);
        junk_in();
        tick();
      end
    end else tick();
`else
    tick();
`endif
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_res"}, alu_result, res);
    chk({tag, "_zero"}, 32'(zero), 32'(res == 32'd0));
    chk({tag, "_wb"}, 32'(wb_out), 32'(wb));
    chk({tag, "_m"}, 32'(m_out), 32'(m));
    chk({tag, "_dest"}, 32'(dest_reg), 32'(dst));
    chk({tag, "_bt"}, branch_target, bt);
    if (!is_mul) chk({tag, "_wd"}, write_data, wd);
  endtask

  initial begin
    logic [5:0] fts [7];
    logic [31:0] a;
    fts = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h18, 6'h3f};
    reset = 1'b1;
    set_in(2'd2, 1'b1, 1'b1, 32'h1234, 32'hdead, 32'hbeef, 32'h20, 5'd3, 5'd7, 2'b11, 3'b111);
    tick();
    tick();
    chk("rst_wb", 32'(wb_out), 32'd0);
    chk("rst_m", 32'(m_out), 32'd0);
    chk("rst_bt", branch_target, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_res", alu_result, 32'd0);
    chk("rst_wd", write_data, 32'd0);
    chk("rst_dest", 32'(dest_reg), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    reset = 1'b0;

    set_in(2'd2, 1'b0, 1'b1, 32'h4, 32'h7fffffff, 32'd1, 32'h20, 5'd1, 5'd2, 2'b10, 3'b000);
    exec_check("add_ovf");
    chk("add_ovf_lit", alu_result, 32'h80000000);
    set_in(2'd1, 1'b0, 1'b0, 32'h8, 32'd5, 32'd5, 32'h0, 5'd4, 5'd2, 2'b00, 3'b100);
    exec_check("sub_zero");
    chk("sub_zero_lit", 32'(zero), 32'd1);
    set_in(2'd2, 1'b0, 1'b1, 32'hc, 32'hffffffff, 32'd1, 32'h2a, 5'd4, 5'd9, 2'b10, 3'b000);
    exec_check("slt");
    chk("slt_lit", alu_result, 32'd1);
    chk("slt_dest_lit", 32'(dest_reg), 32'd9);
    set_in(2'd0, 1'b1, 1'b0, 32'h10, 32'h100, 32'h55, 32'hfffffffc, 5'd8, 5'd0, 2'b11, 3'b010);
    exec_check("lw");
    chk("lw_lit", alu_result, 32'hfc);
    set_in(2'd1, 1'b0, 1'b0, 32'h40, 32'd7, 32'd7, 32'd3, 5'd0, 5'd0, 2'b00, 3'b100);
    exec_check("beq");
    chk("beq_lit", branch_target, 32'h4c);
    set_in(2'd3, 1'b0, 1'b0, 32'h44, 32'd9, 32'd3, 32'h20, 5'd1, 5'd2, 2'b10, 3'b000);
    exec_check("op11");

    set_in(2'd2, 1'b0, 1'b1, 32'h50, 32'd1234, 32'd5678, 32'h18, 5'd3, 5'd12, 2'b10, 3'b000);
    exec_check("mul");
`ifdef EX_MUL_EN
    chk("mul_lit", alu_result, 32'd7006652);
`else
    chk("mul_off_lit", alu_result, 32'd0);
`endif
    set_in(2'd2, 1'b0, 1'b1, 32'h54, 32'hffffffff, 32'd2, 32'h18, 5'd3, 5'd13, 2'b11, 3'b001);
    exec_check("mul_neg");
`ifdef EX_MUL_EN
    chk("mul_neg_lit", alu_result, 32'hfffffffe);
`endif
    set_in(2'd2, 1'b0, 1'b1, 32'h58, 32'd3, 32'd4, 32'h18, 5'd3, 5'd14, 2'b01, 3'b010);
    exec_check("mul_b2b");

`ifdef EX_MUL_EN
    set_in(2'd2, 1'b0, 1'b1, 32'h60, 32'd1234, 32'd5678, 32'h18, 5'd3, 5'd12, 2'b10, 3'b000);
    tick();
    repeat (10) tick();
    chk("abort_busy", 32'(stall_out), 32'd1);
    reset = 1'b1;
    set_in(2'd3, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, 3'b000);
    tick();
    reset = 1'b0;
    chk("abort_stall", 32'(stall_out), 32'd0);
    chk("abort_wb", 32'(wb_out), 32'd0);
    for (int i = 0; i < 35; i++) begin
      tick();
      chk("abort_late", alu_result | 32'(stall_out) | 32'(wb_out), 32'd0);
    end
`endif

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      set_in(2'($urandom), 1'($urandom), 1'($urandom), $urandom, a,
             ($urandom_range(0, 3) == 0) ? a : $urandom,
             {$urandom_range(0, 1) ? 26'h3ffffff : 26'($urandom), fts[$urandom_range(0, 6)]},
             5'($urandom), 5'($urandom), 2'($urandom), 3'($urandom));
      if (alu_src && imm_in[5:0] != 6'h18 && $urandom_range(0, 3) == 0) read_data2_in = imm_in;
      exec_check("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
